ppu_cpu_regs: RTL and testbench
===============================

Name: ppu_cpu_regs

Overview:
CPU-facing responder for the PPU register window $2000-$2007 (address bits [2:0] only; mirroring is done by the upstream bus decode). It holds PPUCTRL/PPUMASK/OAMADDR/scroll/VRAM-address state and the shared write toggle. It generates NMI_n and the status flags. It converts $2007 accesses into single-beat PPU-bus reads and writes via a small request/grant FSM. It sits inside the PPU, between the CPU-bus decode strobes and the PPU address/data bus.

Parameters:
VRAM_RD_LAT, 1, CLK cycles from PPU_READ to valid PPU_DATA_IN (sync RAM).

Ports:
CLK  in  1  PPU clock; everything sampled on rising edge.
RESET_n  in  1  asynchronous, active-low reset.
CPU_STB  in  1  one-CLK pulse per CPU cycle; commits the access.
CPU_ADDR  in  3  register select.
CPU_DATA_IN  in  8  CPU write data.
CPU_wren  in  1  write qualifier.
CPU_rden  in  1  read qualifier.
CPU_DATA_OUT  out  8  read data (combinational from registers, stable all CPU cycle).
VBLANK_SET  in  1  pulse: scanline 241 dot 1.
VBLANK_CLR  in  1  pulse: pre-render; also clears SPR0_HIT/SPR_OVF.
SPR0_HIT_SET, SPR_OVF_SET  in  1 each  pulses from renderer.
NMI_n  out  1  registered, active-low.
CTRL, MASK  out  8 each  PPUCTRL/PPUMASK to renderer.
SCROLL_X, SCROLL_Y  out  8 each  scroll values.
OAM_ADDR  out  8 | OAM_WE  out  1 | OAM_WDATA  out  8 | OAM_RDATA  in  8.
VRAM_REQ  out  1 | VRAM_GNT  in  1  bus arbitration with renderer.
PPU_ADDR  out  14 | PPU_DATA_OUT  out  8 | PPU_DATA_IN  in  8.
PPU_READ, PPU_WRITE  out  1 each.
DBG_OVERRUN  out  1  sticky; set when a $2007 access is dropped.

Behaviour:
- Reset (async, RESET_n=0): all registers 0, w=0, v=0, read buffer 0, io latch 0, FSM IDLE, NMI_n=1, all strobes 0, DBG_OVERRUN=0. Reset mid-transfer abandons the transfer and performs no write.
- Access takes effect only on CLK where CPU_STB & (CPU_wren|CPU_rden). With both wren and rden high, the write wins.
- io latch: loaded with CPU_DATA_IN on every write, and with CPU_DATA_OUT on every read.
- Writes:
  - 0: CTRL.
  - 1: MASK.
  - 3: OAM_ADDR.
  - 4: OAM_WE pulses 1 CLK with OAM_WDATA; OAM_ADDR +1 (8-bit wrap).
  - 5: w=0 sets SCROLL_X, w=1 sets SCROLL_Y; toggle w.
  - 6: w=0 sets t[13:8]=data[5:0]; w=1 sets t[7:0]=data and copies v=t; toggle w.
  - 7: enqueue VRAM write at v with data; then v += CTRL[2] ? 32 : 1, mod 2^14.
- Reads:
  - 2: returns {vblank, spr0, ovf, io[4:0]}; side effects clear vblank and w.
  - 4: returns OAM_RDATA; no increment.
  - 7: returns read buffer; enqueue VRAM read at v; v increments as for writes. Palette range uses the same buffered path (no special case).
  - 0/1/3/5/6: return io latch.
- VRAM FSM:
  - IDLE: on enqueue, latch addr/dir/data and go to REQ.
  - REQ: VRAM_REQ=1; on GNT go to ACC.
  - ACC: PPU_ADDR driven; PPU_READ or PPU_WRITE high exactly 1 CLK. Write goes to IDLE; read goes to WAIT.
  - WAIT: VRAM_RD_LAT cycles, then load buffer from PPU_DATA_IN and go to IDLE.
  - VRAM_REQ stays high REQ through WAIT.
  - One-deep pending slot: an enqueue while the FSM is busy is held. An enqueue while the slot is also full is dropped and sets DBG_OVERRUN.
- Status flags:
  - Set by the *_SET pulses; cleared by VBLANK_CLR.
  - VBLANK_SET on the same CLK as a committed $2002 read: read returns bit7=0, flag stays 0, and no NMI is raised this frame.
- NMI_n: registered ~(vblank & CTRL[7]). Writing CTRL[7] 0→1 while vblank=1 drops NMI_n on the next CLK.

Decomposition:
- ppu_pkg:
  - register offset localparams (PPUCTRL..PPUDATA = 0..7)
  - CTRL bit indices (NMI_EN=7, INC32=2)
  - vram_fsm_t enum {IDLE, REQ, ACC, WAIT}
  - a 14-bit vram_addr_t typedef
- One sub-module, ppu_vram_port: the FSM plus the pending slot, with ports enqueue/dir/addr/wdata → PPU bus, and rdata_valid/rdata back.

Test Plan:
- Write $2006←$21, $2006←$08, $2007←$5A -> one PPU_WRITE pulse at PPU_ADDR=$2108 with data $5A; v=$2109.
- CTRL=$04, v=$3FF0, $2007 write -> access at $3FF0, v=$0010 (14-bit wrap with +32).
- VRAM[$2000]=$11, VRAM[$2001]=$22; set v=$2000; read $2007 ×3 -> returns $00, $11, $22 (buffer priming).
- CTRL=$80, pulse VBLANK_SET -> NMI_n=0 next CLK; read $2002 -> $80|io[4:0]; NMI_n returns to 1; second read gives bit7=0.
- VBLANK_SET coincident with a $2002 read -> returns bit7=0, NMI_n stays 1; also check $2006 single write then $2002 read resets w.
- Hold VRAM_GNT=0 and issue 3 $2007 writes -> first in FSM, second pending, third dropped with DBG_OVERRUN=1. Assert RESET_n=0 mid-REQ -> no PPU_WRITE, all outputs at reset values.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU CPU register window: register offsets, PPUCTRL bits,
// VRAM port FSM states and the 14-bit PPU address type.
package ppu_pkg;

    localparam logic [2:0] PPUCTRL   = 3'd0;
    localparam logic [2:0] PPUMASK   = 3'd1;
    localparam logic [2:0] PPUSTATUS = 3'd2;
    localparam logic [2:0] OAMADDR   = 3'd3;
    localparam logic [2:0] OAMDATA   = 3'd4;
    localparam logic [2:0] PPUSCROLL = 3'd5;
    localparam logic [2:0] PPUADDR   = 3'd6;
    localparam logic [2:0] PPUDATA   = 3'd7;

    localparam int NMI_EN = 7;
    localparam int INC32  = 2;

    typedef enum logic [1:0] {IDLE, REQ, ACC, WAIT} vram_fsm_t;

    typedef logic [13:0] vram_addr_t;

    // One queued $2007 access; dir=1 is a write.
    typedef struct packed {
        logic       dir;
        vram_addr_t addr;
        logic [7:0] data;
    } vram_op_t;

    // PPUDATA address step; the 14-bit type gives the wrap for free.
    function automatic vram_addr_t vram_step(input vram_addr_t a, input logic inc32);
        return a + (inc32 ? 14'd32 : 14'd1);
    endfunction

endpackage

// File: rtl/ppu_vram_port.sv
// Single-beat PPU-bus master for $2007 accesses, with a one-deep pending slot.
// Latency: enqueue -> REQ next CLK, one ACC CLK after grant, reads add VRAM_RD_LAT CLKs.
// Backpressure: waits on vram_gnt; a third outstanding access is dropped and flags overrun.
module ppu_vram_port
    import ppu_pkg::*;
#(
    parameter int VRAM_RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enqueue,
    input  logic       dir,
    input  vram_addr_t addr,
    input  logic [7:0] wdata,
    output logic       vram_req,
    input  logic       vram_gnt,
    output vram_addr_t ppu_addr,
    output logic [7:0] ppu_data_out,
    input  logic [7:0] ppu_data_in,
    output logic       ppu_read,
    output logic       ppu_write,
    output logic       rdata_valid,
    output logic [7:0] rdata,
    output logic       overrun
);

    localparam int CW = (VRAM_RD_LAT > 1) ? $clog2(VRAM_RD_LAT) : 1;

    vram_fsm_t      state;
    vram_op_t       cur;
    vram_op_t       pend;
    logic           pend_vld;
    logic [CW-1:0]  lat_cnt;
    vram_op_t       new_op;

    assign new_op = '{dir: dir, addr: addr, data: wdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur      <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            lat_cnt  <= '0;
            overrun  <= 1'b0;
        end else begin
            if (state == IDLE) begin
                // Pending slot drains first; a same-cycle enqueue refills it.
                if (pend_vld) begin
                    cur      <= pend;
                    state    <= REQ;
                    pend_vld <= enqueue;
                    if (enqueue)
                        pend <= new_op;
                end else if (enqueue) begin
                    cur   <= new_op;
                    state <= REQ;
                end
            end else begin
                if (enqueue) begin
                    if (!pend_vld) begin
                        pend     <= new_op;
                        pend_vld <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end
                case (state)
                    REQ: if (vram_gnt) state <= ACC;
                    ACC: begin
                        state   <= cur.dir ? IDLE : WAIT;
                        lat_cnt <= CW'(VRAM_RD_LAT - 1);
                    end
                    WAIT: begin
                        if (lat_cnt == '0)
                            state <= IDLE;
                        else
                            lat_cnt <= lat_cnt - 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign vram_req     = (state != IDLE);
    assign ppu_addr     = cur.addr;
    assign ppu_data_out = cur.data;
    assign ppu_write    = (state == ACC) &&  cur.dir;
    assign ppu_read     = (state == ACC) && !cur.dir;
    assign rdata_valid  = (state == WAIT) && (lat_cnt == '0);
    assign rdata        = ppu_data_in;

endmodule

// File: rtl/ppu_cpu_regs.sv
// CPU-side PPU register window $2000-$2007: control/scroll/address state, status, NMI.
// Latency: register writes visible next CLK, reads combinational; $2007 via ppu_vram_port.
// Backpressure: none toward the CPU; excess $2007 traffic is dropped and DBG_OVERRUN set.
module ppu_cpu_regs
    import ppu_pkg::*;
#(
    parameter int VRAM_RD_LAT = 1
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        CPU_STB,
    input  logic [2:0]  CPU_ADDR,
    input  logic [7:0]  CPU_DATA_IN,
    input  logic        CPU_wren,
    input  logic        CPU_rden,
    output logic [7:0]  CPU_DATA_OUT,
    input  logic        VBLANK_SET,
    input  logic        VBLANK_CLR,
    input  logic        SPR0_HIT_SET,
    input  logic        SPR_OVF_SET,
    output logic        NMI_n,
    output logic [7:0]  CTRL,
    output logic [7:0]  MASK,
    output logic [7:0]  SCROLL_X,
    output logic [7:0]  SCROLL_Y,
    output logic [7:0]  OAM_ADDR,
    output logic        OAM_WE,
    output logic [7:0]  OAM_WDATA,
    input  logic [7:0]  OAM_RDATA,
    output logic        VRAM_REQ,
    input  logic        VRAM_GNT,
    output logic [13:0] PPU_ADDR,
    output logic [7:0]  PPU_DATA_OUT,
    input  logic [7:0]  PPU_DATA_IN,
    output logic        PPU_READ,
    output logic        PPU_WRITE,
    output logic        DBG_OVERRUN
);

    logic       wr, rd;
    logic       w;
    vram_addr_t t, v;
    logic [7:0] io_latch;
    logic [7:0] rd_buf;
    logic       vblank, spr0, ovf;
    logic       vram_enq;
    logic       rdata_valid;
    logic [7:0] rdata;

    // Write wins when both qualifiers are set.
    assign wr       = CPU_STB && CPU_wren;
    assign rd       = CPU_STB && !CPU_wren && CPU_rden;
    assign vram_enq = (wr || rd) && (CPU_ADDR == PPUDATA);

    always_comb begin
        CPU_DATA_OUT = io_latch;
        case (CPU_ADDR)
            PPUSTATUS: CPU_DATA_OUT = {vblank, spr0, ovf, io_latch[4:0]};
            OAMDATA:   CPU_DATA_OUT = OAM_RDATA;
            PPUDATA:   CPU_DATA_OUT = rd_buf;
            default:   CPU_DATA_OUT = io_latch;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            CTRL      <= '0;
            MASK      <= '0;
            SCROLL_X  <= '0;
            SCROLL_Y  <= '0;
            OAM_ADDR  <= '0;
            OAM_WE    <= 1'b0;
            OAM_WDATA <= '0;
            w         <= 1'b0;
            t         <= '0;
            v         <= '0;
            io_latch  <= '0;
            rd_buf    <= '0;
            vblank    <= 1'b0;
            spr0      <= 1'b0;
            ovf       <= 1'b0;
            NMI_n     <= 1'b1;
        end else begin
            OAM_WE <= wr && (CPU_ADDR == OAMDATA);
            if (wr)
                io_latch <= CPU_DATA_IN;
            else if (rd)
                io_latch <= CPU_DATA_OUT;

            // OAM_ADDR advances after the write pulse so the strobe sees the target slot.
            if (wr && CPU_ADDR == OAMADDR)
                OAM_ADDR <= CPU_DATA_IN;
            else if (OAM_WE)
                OAM_ADDR <= OAM_ADDR + 8'd1;

            if (wr) begin
                case (CPU_ADDR)
                    PPUCTRL: CTRL <= CPU_DATA_IN;
                    PPUMASK: MASK <= CPU_DATA_IN;
                    OAMDATA: OAM_WDATA <= CPU_DATA_IN;
                    PPUSCROLL: begin
                        if (!w) SCROLL_X <= CPU_DATA_IN;
                        else    SCROLL_Y <= CPU_DATA_IN;
                        w <= !w;
                    end
                    PPUADDR: begin
                        if (!w) begin
                            t[13:8] <= CPU_DATA_IN[5:0];
                        end else begin
                            t[7:0] <= CPU_DATA_IN;
                            v      <= {t[13:8], CPU_DATA_IN};
                        end
                        w <= !w;
                    end
                    default: ;
                endcase
            end

            if (rd && CPU_ADDR == PPUSTATUS)
                w <= 1'b0;
            if (vram_enq)
                v <= vram_step(v, CTRL[INC32]);
            if (rdata_valid)
                rd_buf <= rdata;

            // A status read racing VBLANK_SET suppresses the flag for this frame.
            if (VBLANK_CLR || (rd && CPU_ADDR == PPUSTATUS))
                vblank <= 1'b0;
            else if (VBLANK_SET)
                vblank <= 1'b1;
            if (VBLANK_CLR) begin
                spr0 <= 1'b0;
                ovf  <= 1'b0;
            end else begin
                if (SPR0_HIT_SET) spr0 <= 1'b1;
                if (SPR_OVF_SET)  ovf  <= 1'b1;
            end

            NMI_n <= !(vblank && CTRL[NMI_EN]);
        end
    end

    ppu_vram_port #(
        .VRAM_RD_LAT (VRAM_RD_LAT)
    ) u_vram_port (
        .clk          (CLK),
        .rst_n        (RESET_n),
        .enqueue      (vram_enq),
        .dir          (wr),
        .addr         (v),
        .wdata        (CPU_DATA_IN),
        .vram_req     (VRAM_REQ),
        .vram_gnt     (VRAM_GNT),
        .ppu_addr     (PPU_ADDR),
        .ppu_data_out (PPU_DATA_OUT),
        .ppu_data_in  (PPU_DATA_IN),
        .ppu_read     (PPU_READ),
        .ppu_write    (PPU_WRITE),
        .rdata_valid  (rdata_valid),
        .rdata        (rdata),
        .overrun      (DBG_OVERRUN)
    );

endmodule

// File: tb/tb_ppu_cpu_regs.sv
// Directed bench for ppu_cpu_regs with a synchronous one-cycle VRAM model.
module tb_ppu_cpu_regs;

    logic        CLK = 1'b0;
    logic        RESET_n;
    logic        CPU_STB = 1'b0;
    logic [2:0]  CPU_ADDR = '0;
    logic [7:0]  CPU_DATA_IN = '0;
    logic        CPU_wren = 1'b0;
    logic        CPU_rden = 1'b0;
    logic [7:0]  CPU_DATA_OUT;
    logic        VBLANK_SET = 1'b0;
    logic        VBLANK_CLR = 1'b0;
    logic        SPR0_HIT_SET = 1'b0;
    logic        SPR_OVF_SET = 1'b0;
    logic        NMI_n;
    logic [7:0]  CTRL, MASK, SCROLL_X, SCROLL_Y;
    logic [7:0]  OAM_ADDR;
    logic        OAM_WE;
    logic [7:0]  OAM_WDATA;
    logic [7:0]  OAM_RDATA = 8'hC3;
    logic        VRAM_REQ;
    logic        VRAM_GNT = 1'b1;
    logic [13:0] PPU_ADDR;
    logic [7:0]  PPU_DATA_OUT;
    logic [7:0]  PPU_DATA_IN = '0;
    logic        PPU_READ, PPU_WRITE;
    logic        DBG_OVERRUN;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          wr_cnt   = 0;
    logic [13:0] last_wa  = '0;
    logic [7:0]  last_wd  = '0;
    logic [7:0]  mem [0:16383];
    logic [7:0]  rdat;
    int          base;

    ppu_cpu_regs #(.VRAM_RD_LAT(1)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .CPU_STB(CPU_STB), .CPU_ADDR(CPU_ADDR),
        .CPU_DATA_IN(CPU_DATA_IN), .CPU_wren(CPU_wren), .CPU_rden(CPU_rden),
        .CPU_DATA_OUT(CPU_DATA_OUT), .VBLANK_SET(VBLANK_SET), .VBLANK_CLR(VBLANK_CLR),
        .SPR0_HIT_SET(SPR0_HIT_SET), .SPR_OVF_SET(SPR_OVF_SET), .NMI_n(NMI_n),
        .CTRL(CTRL), .MASK(MASK), .SCROLL_X(SCROLL_X), .SCROLL_Y(SCROLL_Y),
        .OAM_ADDR(OAM_ADDR), .OAM_WE(OAM_WE), .OAM_WDATA(OAM_WDATA), .OAM_RDATA(OAM_RDATA),
        .VRAM_REQ(VRAM_REQ), .VRAM_GNT(VRAM_GNT), .PPU_ADDR(PPU_ADDR),
        .PPU_DATA_OUT(PPU_DATA_OUT), .PPU_DATA_IN(PPU_DATA_IN), .PPU_READ(PPU_READ),
        .PPU_WRITE(PPU_WRITE), .DBG_OVERRUN(DBG_OVERRUN)
    );

    always #5 CLK = ~CLK;

    // Synchronous RAM: read data valid the CLK after PPU_READ.
    always @(posedge CLK) begin
        if (PPU_WRITE) begin
            mem[PPU_ADDR] <= PPU_DATA_OUT;
            wr_cnt        <= wr_cnt + 1;
            last_wa       <= PPU_ADDR;
            last_wd       <= PPU_DATA_OUT;
        end
        if (PPU_READ)
            PPU_DATA_IN <= mem[PPU_ADDR];
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One CPU cycle; read data is sampled before the committing edge.
    task automatic cpu(input logic [2:0] a, input logic [7:0] d, input logic we,
                       input logic vs, output logic [7:0] r);
        @(negedge CLK);
        CPU_ADDR = a; CPU_DATA_IN = d; CPU_wren = we; CPU_rden = !we;
        CPU_STB = 1'b1; VBLANK_SET = vs;
        #1 r = CPU_DATA_OUT;
        @(negedge CLK);
        CPU_STB = 1'b0; CPU_wren = 1'b0; CPU_rden = 1'b0; VBLANK_SET = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] dummy;
        cpu(a, d, 1'b1, 1'b0, dummy);
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] r);
        cpu(a, 8'h00, 1'b0, 1'b0, r);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET_n = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_n = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        RESET_n = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_nmi",     {15'd0, NMI_n}, 16'd1);
        check("rst_ctrl",    {8'd0, CTRL}, 16'h0000);
        check("rst_req",     {15'd0, VRAM_REQ}, 16'd0);
        check("rst_ovr",     {15'd0, DBG_OVERRUN}, 16'd0);
        check("rst_oam_we",  {15'd0, OAM_WE}, 16'd0);
        check("rst_io",      {8'd0, CPU_DATA_OUT}, 16'h0000);
        RESET_n = 1'b1;
        @(negedge CLK);

        // $2006/$2007 write path and v increment by 1
        wr(3'd6, 8'h21); wr(3'd6, 8'h08); wr(3'd7, 8'h5A);
        check("w1_cnt",  16'(wr_cnt), 16'd1);
        check("w1_addr", {2'b0, last_wa}, 16'h2108);
        check("w1_data", {8'd0, last_wd}, 16'h005A);
        wr(3'd7, 8'h77);
        check("w1_vinc", {2'b0, last_wa}, 16'h2109);

        // +32 increment with 14-bit wrap
        wr(3'd0, 8'h04); wr(3'd6, 8'h3F); wr(3'd6, 8'hF0); wr(3'd7, 8'h33);
        check("w32_addr", {2'b0, last_wa}, 16'h3FF0);
        wr(3'd7, 8'h34);
        check("w32_wrap", {2'b0, last_wa}, 16'h0010);

        // Buffered $2007 reads
        do_reset();
        wr(3'd6, 8'h20); wr(3'd6, 8'h00); wr(3'd7, 8'h11); wr(3'd7, 8'h22);
        wr(3'd6, 8'h20); wr(3'd6, 8'h00);
        rd(3'd7, rdat); check("rbuf0", {8'd0, rdat}, 16'h0000);
        rd(3'd7, rdat); check("rbuf1", {8'd0, rdat}, 16'h0011);
        rd(3'd7, rdat); check("rbuf2", {8'd0, rdat}, 16'h0022);

        // VBLANK / NMI / status
        do_reset();
        wr(3'd0, 8'h80); wr(3'd1, 8'h1F);
        check("mask", {8'd0, MASK}, 16'h001F);
        @(negedge CLK); VBLANK_SET = 1'b1;
        @(negedge CLK); VBLANK_SET = 1'b0;
        @(negedge CLK);
        check("nmi_low", {15'd0, NMI_n}, 16'd0);
        rd(3'd2, rdat); check("stat_vbl", {8'd0, rdat}, 16'h009F);
        check("nmi_rel", {15'd0, NMI_n}, 16'd1);
        rd(3'd2, rdat); check("stat_clr", {8'd0, rdat}, 16'h001F);
        @(negedge CLK); SPR0_HIT_SET = 1'b1; SPR_OVF_SET = 1'b1;
        @(negedge CLK); SPR0_HIT_SET = 1'b0; SPR_OVF_SET = 1'b0;
        rd(3'd2, rdat); check("stat_spr", {8'd0, rdat}, 16'h007F);
        @(negedge CLK); VBLANK_CLR = 1'b1;
        @(negedge CLK); VBLANK_CLR = 1'b0;
        rd(3'd2, rdat); check("stat_vclr", {8'd0, rdat}, 16'h001F);

        // VBLANK_SET racing a $2002 read
        cpu(3'd2, 8'h00, 1'b0, 1'b1, rdat);
        check("race_rd", {8'd0, rdat}, 16'h001F);
        repeat (3) @(negedge CLK);
        check("race_nmi", {15'd0, NMI_n}, 16'd1);
        rd(3'd2, rdat); check("race_flag", {8'd0, rdat}, 16'h001F);

        // $2002 read resets the write toggle
        wr(3'd6, 8'h25);
        rd(3'd2, rdat); check("w_io", {8'd0, rdat}, 16'h0005);
        wr(3'd6, 8'h21); wr(3'd6, 8'h00); wr(3'd7, 8'h44);
        check("w_reset", {2'b0, last_wa}, 16'h2100);
        check("w_data",  {8'd0, last_wd}, 16'h0044);

        // Scroll and OAM
        wr(3'd5, 8'h12); wr(3'd5, 8'h34);
        check("scroll", {SCROLL_X, SCROLL_Y}, 16'h1234);
        wr(3'd3, 8'h10);
        @(negedge CLK);
        CPU_ADDR = 3'd4; CPU_DATA_IN = 8'hAB; CPU_wren = 1'b1; CPU_STB = 1'b1;
        @(negedge CLK);
        CPU_STB = 1'b0; CPU_wren = 1'b0;
        check("oam_we",    {15'd0, OAM_WE}, 16'd1);
        check("oam_wdata", {OAM_ADDR, OAM_WDATA}, 16'h10AB);
        @(negedge CLK);
        check("oam_we_off", {15'd0, OAM_WE}, 16'd0);
        check("oam_inc",    {8'd0, OAM_ADDR}, 16'h0011);
        rd(3'd4, rdat); check("oam_rd", {8'd0, rdat}, 16'h00C3);

        // Pending slot, overrun, reset mid-transfer
        do_reset();
        VRAM_GNT = 1'b0;
        wr(3'd6, 8'h20); wr(3'd6, 8'h00);
        base = wr_cnt;
        wr(3'd7, 8'hA1); wr(3'd7, 8'hA2); wr(3'd7, 8'hA3);
        check("ovr_set",  {15'd0, DBG_OVERRUN}, 16'd1);
        check("ovr_req",  {15'd0, VRAM_REQ}, 16'd1);
        check("ovr_hold", 16'(wr_cnt - base), 16'd0);
        VRAM_GNT = 1'b1;
        repeat (12) @(negedge CLK);
        check("ovr_cnt",  16'(wr_cnt - base), 16'd2);
        check("ovr_last", {last_wd, last_wa[7:0]}, 16'hA201);
        VRAM_GNT = 1'b0;
        base = wr_cnt;
        wr(3'd7, 8'hB0);
        RESET_n = 1'b0;
        #1;
        check("mid_req",  {15'd0, VRAM_REQ}, 16'd0);
        check("mid_ovr",  {15'd0, DBG_OVERRUN}, 16'd0);
        check("mid_strb", {14'd0, PPU_READ, PPU_WRITE}, 16'd0);
        check("mid_nmi",  {15'd0, NMI_n}, 16'd1);
        VRAM_GNT = 1'b1;
        repeat (3) @(negedge CLK);
        RESET_n = 1'b1;
        repeat (8) @(negedge CLK);
        check("mid_nowr", 16'(wr_cnt - base), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
